// File: rtl/handshake_sender.sv
// Source side of a four-phase req/ack crossing: holds a word on xfer_data while xfer_req is up,
// waits for the synchronized ack to rise and then fall, and counts offers refused while busy.
module handshake_sender #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W      = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              send_valid,
  input  logic [WIDTH-1:0]  send_data,
  output logic              send_ready,
  input  logic              drop_clr,
  output logic              xfer_req,
  output logic [WIDTH-1:0]  xfer_data,
  input  logic              xfer_ack,
  output logic              done,
  output logic [DROP_W-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   accept;
  logic                   drop;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (ack_s)  state_nxt = RELEASE;
      RELEASE: if (!ack_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A stale high ack left over from a previous exchange blocks the next accept.
  always_comb begin
    send_ready = (state == IDLE) && !ack_s;
    accept     = send_valid && send_ready;
    drop       = send_valid && !send_ready;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      done      <= 1'b0;
    end else begin
      xfer_req <= (state_nxt == REQ);
      done     <= (state == RELEASE) && !ack_s;
      if (accept) xfer_data <= send_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                         drop_count <= '0;
    else if (drop_clr)                  drop_count <= '0;
    else if (drop && drop_count != '1)  drop_count <= drop_count + 1'b1;
  end

endmodule

// File: tb/tb_handshake_sender.sv
// Randomized bench for handshake_sender with a transaction-level reference model and a remote responder.
module tb_handshake_sender;
  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int DROP_W      = 8;
  localparam int DROP_MAX    = (1 << DROP_W) - 1;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              send_valid = 1'b0;
  logic [WIDTH-1:0]  send_data = '0;
  logic              send_ready;
  logic              drop_clr = 1'b0;
  logic              xfer_req;
  logic [WIDTH-1:0]  xfer_data;
  logic              xfer_ack = 1'b0;
  logic              done;
  logic [DROP_W-1:0] drop_count;

  handshake_sender #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DROP_W(DROP_W)) dut (
    .clock(clock), .rst_n(rst_n), .send_valid(send_valid), .send_data(send_data),
    .send_ready(send_ready), .drop_clr(drop_clr), .xfer_req(xfer_req), .xfer_data(xfer_data),
    .xfer_ack(xfer_ack), .done(done), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one outstanding word, plus "waiting for ack to return low".
  bit             m_busy, m_wait_low, m_done;
  logic [WIDTH-1:0] m_data;
  int             m_drops;
  bit             ahist[$];

  // Remote responder controls
  bit ack_force = 0;
  bit rand_dly  = 0;
  int rdly = 3;
  int rcnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ack_s();
    return (ahist.size() >= SYNC_STAGES) ? ahist[ahist.size() - SYNC_STAGES] : 1'b0;
  endfunction

  function automatic bit m_ready();
    return !m_busy && !m_wait_low && !m_ack_s();
  endfunction

  task automatic model_reset();
    m_busy = 0; m_wait_low = 0; m_done = 0; m_data = '0; m_drops = 0;
    ahist.delete();
  endtask

  task automatic respond();
    if (ack_force) xfer_ack = 1'b1;
    else if (xfer_req != xfer_ack) begin
      rcnt++;
      if (rcnt >= rdly) begin
        xfer_ack = xfer_req;
        rcnt = 0;
        if (rand_dly) rdly = $urandom_range(0, 4);
      end
    end else rcnt = 0;
  endtask

  // Compare the current cycle against the model, then advance both by one edge.
  task automatic step(input bit glitch);
    bit acks, rdy, n_busy, n_wl, n_done, raw;
    logic [WIDTH-1:0] n_data;
    int n_drops;
    acks = m_ack_s();
    rdy  = m_ready();
    check_eq("send_ready", 64'(send_ready), 64'(rdy));
    check_eq("xfer_req",   64'(xfer_req),   64'(m_busy));
    check_eq("xfer_data",  64'(xfer_data),  64'(m_data));
    check_eq("done",       64'(done),       64'(m_done));
    check_eq("drop_count", 64'(drop_count), 64'(m_drops));
    n_busy = m_busy; n_wl = m_wait_low; n_data = m_data; n_drops = m_drops;
    if (send_valid && rdy) begin
      n_busy = 1; n_data = send_data;
    end else if (m_busy && acks) begin
      n_busy = 0; n_wl = 1;
    end else if (m_wait_low && !acks) begin
      n_wl = 0;
    end
    n_done = m_wait_low && !acks;
    if (drop_clr) n_drops = 0;
    else if (send_valid && !rdy && m_drops < DROP_MAX) n_drops++;
    raw = xfer_ack;
    if (glitch && !xfer_ack) begin
      #3 xfer_ack = 1'b1;
      #1 xfer_ack = 1'b0;
    end
    @(posedge clock); #1;
    ahist.push_back(raw);
    while (ahist.size() > SYNC_STAGES) void'(ahist.pop_front());
    m_busy = n_busy; m_wait_low = n_wl; m_done = n_done; m_data = n_data; m_drops = n_drops;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; xfer_ack = 1'b0; send_valid = 1'b0; drop_clr = 1'b0;
    ack_force = 0; rcnt = 0;
    model_reset();
    @(posedge clock); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    send_valid = 1'b0;
    ack_force = 0;
    while (!(m_ready() && !xfer_ack && !m_done) && c < maxc) begin
      respond();
      step(0);
      c++;
    end
    if (c >= maxc) check_eq("drain_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    int dones;
    bit got_b;

    // Reset state
    do_reset();
    check_eq("rst_req",   64'(xfer_req),   64'(0));
    check_eq("rst_data",  64'(xfer_data),  64'(0));
    check_eq("rst_done",  64'(done),       64'(0));
    check_eq("rst_drops", 64'(drop_count), 64'(0));
    check_eq("rst_ready", 64'(send_ready), 64'(1));

    // Single transfer of 0x1234 with fixed 3-cycle remote response
    rdly = 3; rand_dly = 0;
    send_valid = 1'b1; send_data = 32'h0000_1234;
    respond(); step(0);
    send_valid = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      send_data = $urandom();
      if (done) dones++;
      respond(); step(0);
    end
    check_eq("t1_dones", 64'(dones), 64'(1));
    check_eq("t1_data",  64'(xfer_data), 64'(32'h1234));
    check_eq("t1_ready", 64'(send_ready), 64'(1));

    // Back-to-back offers with valid held high
    send_valid = 1'b1; send_data = 32'hA; got_b = 0;
    for (int i = 0; i < 60 && !got_b; i++) begin
      bit acc;
      acc = m_ready();
      respond(); step(0);
      if (acc) begin
        if (send_data == 32'hA) send_data = 32'hB;
        else got_b = 1;
      end
    end
    send_valid = 1'b0;
    check_eq("t2_got_b", 64'(got_b), 64'(1));
    check_eq("t2_data",  64'(xfer_data), 64'(32'hB));
    drain(60);

    // Stale high ack before any offer
    do_reset();
    ack_force = 1;
    for (int i = 0; i < 3; i++) begin respond(); step(0); end
    check_eq("t3_ready_low", 64'(send_ready), 64'(0));
    send_valid = 1'b1; send_data = 32'h55;
    respond(); step(0);
    send_valid = 1'b0;
    check_eq("t3_drop1", 64'(drop_count), 64'(1));
    ack_force = 0; rdly = 0;
    respond(); step(0);
    check_eq("t3_ready_1cyc", 64'(send_ready), 64'(0));
    respond(); step(0);
    check_eq("t3_ready_2cyc", 64'(send_ready), 64'(1));

    // Drop counter saturation and clear priority
    do_reset();
    ack_force = 1;
    for (int i = 0; i < 3; i++) begin respond(); step(0); end
    send_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin respond(); step(0); end
    check_eq("t4_sat", 64'(drop_count), 64'(DROP_MAX));
    drop_clr = 1'b1;
    respond(); step(0);
    drop_clr = 1'b0; send_valid = 1'b0;
    check_eq("t4_clr", 64'(drop_count), 64'(0));
    rdly = 2;
    drain(40);

    // Reset in the middle of a request
    do_reset();
    rdly = 10;
    send_valid = 1'b1; send_data = 32'hDEAD_BEEF;
    respond(); step(0);
    send_valid = 1'b0;
    respond(); step(0);
    respond(); step(0);
    check_eq("t5_req_before", 64'(xfer_req), 64'(1));
    #3 rst_n = 1'b0;
    #1;
    check_eq("t5_req_async",  64'(xfer_req),  64'(0));
    check_eq("t5_data_async", 64'(xfer_data), 64'(0));
    xfer_ack = 1'b0; rcnt = 0;
    model_reset();
    @(posedge clock); #1;
    rst_n = 1'b1;
    check_eq("t5_ready", 64'(send_ready), 64'(1));
    respond(); step(0);

    // Randomized traffic with random remote latency and short ack glitches
    rand_dly = 1; rdly = 1;
    for (int i = 0; i < 3000; i++) begin
      send_valid = ($urandom_range(0, 1) == 1);
      send_data  = $urandom();
      drop_clr   = ($urandom_range(0, 49) == 0);
      respond();
      step($urandom_range(0, 9) == 0);
    end
    drop_clr = 1'b0;
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
